// File: rtl/sens_event_monitor.sv
// Watches level a, rising b and falling c; toggles d once per event cycle, counts each class, queues masks.
// Results visible one edge after the input changes; a full FIFO with no pop drops the mask and sets overflow.
module sens_event_monitor #(
   parameter int CNT_W      = 8,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   output logic             d,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
   output logic [CNT_W-1:0] cnt_c,
   output logic             ev_valid,
   output logic [2:0]       ev_data,
   input  logic             ev_ready,
   output logic             overflow,
   input  logic             clr_ovf
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic                  a_q, b_q, c_q;
   logic                  a_d, b_d, c_d;
   logic                  d_q, d_d;
   logic [CNT_W-1:0]      cnt_a_q, cnt_b_q, cnt_c_q;
   logic [CNT_W-1:0]      cnt_a_d, cnt_b_d, cnt_c_d;
   logic [2:0]            mem_q [DEPTH];
   logic [2:0]            mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;

   logic [2:0] m;
   logic       ev_any, full, pop, push, drop;

   always_comb begin
      m      = {~c & c_q, b & ~b_q, a ^ a_q};
      ev_any = (m != 3'b000);
      full   = (count_q == CW'(DEPTH));
      pop    = (count_q != '0) && ev_ready;
      // A pop on the same edge frees the slot, so a full FIFO still accepts.
      push   = ev_any && (!full || pop);
      drop   = ev_any && full && !pop;
   end

   always_comb begin
      a_d      = a;
      b_d      = b;
      c_d      = c;
      d_d      = d_q;
      cnt_a_d  = cnt_a_q;
      cnt_b_d  = cnt_b_q;
      cnt_c_d  = cnt_c_q;
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      if (ev_any) begin
         d_d = ~d_q;
      end
      if (m[0] && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + CNT_W'(1);
      if (m[1] && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + CNT_W'(1);
      if (m[2] && (cnt_c_q != CNT_MAX)) cnt_c_d = cnt_c_q + CNT_W'(1);

      if (push) begin
         mem_d[wr_ptr_q] = m;
         wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end

      if (clr_ovf) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_q      <= 1'b0;
         b_q      <= 1'b0;
         c_q      <= 1'b0;
         d_q      <= 1'b0;
         cnt_a_q  <= '0;
         cnt_b_q  <= '0;
         cnt_c_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 3'b000;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         d_q      <= d_d;
         cnt_a_q  <= cnt_a_d;
         cnt_b_q  <= cnt_b_d;
         cnt_c_q  <= cnt_c_d;
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign d        = d_q;
   assign cnt_a    = cnt_a_q;
   assign cnt_b    = cnt_b_q;
   assign cnt_c    = cnt_c_q;
   assign ev_valid = (count_q != '0);
   assign ev_data  = ev_valid ? mem_q[rd_ptr_q] : 3'b000;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_sens_event_monitor.sv
// Bench for sens_event_monitor: queue-based reference model checked every cycle, plus literal expectations.
module tb_sens_event_monitor;

   logic       clock = 1'b0;
   logic       reset_n, a, b, c, ev_ready, clr_ovf;
   logic       d, ev_valid, overflow;
   logic [7:0] cnt_a, cnt_b, cnt_c;
   logic [2:0] ev_data;
   logic       d2, ev_valid2, overflow2;
   logic [1:0] cnt_a2, cnt_b2, cnt_c2;
   logic [2:0] ev_data2;

   int checks = 0;
   int errors = 0;

   sens_event_monitor #(.CNT_W(8), .DEPTH_LOG2(2)) dut (
      .clock(clock), .reset_n(reset_n), .a(a), .b(b), .c(c), .d(d),
      .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c),
      .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
      .overflow(overflow), .clr_ovf(clr_ovf)
   );

   // Narrow-counter instance sharing the same stimulus, to exercise saturation.
   sens_event_monitor #(.CNT_W(2), .DEPTH_LOG2(2)) dut2 (
      .clock(clock), .reset_n(reset_n), .a(a), .b(b), .c(c), .d(d2),
      .cnt_a(cnt_a2), .cnt_b(cnt_b2), .cnt_c(cnt_c2),
      .ev_valid(ev_valid2), .ev_data(ev_data2), .ev_ready(ev_ready),
      .overflow(overflow2), .clr_ovf(clr_ovf)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   // Reference model: event counts as plain integers, FIFO as a queue.
   int         ca, cb, cc;
   logic       md, movf;
   logic       ha, hb, hc;
   logic [2:0] q[$];

   initial begin
      logic [2:0] m;
      logic       pop, full, drop;
      ca = 0; cb = 0; cc = 0; md = 1'b0; movf = 1'b0;
      ha = 1'b0; hb = 1'b0; hc = 1'b0;
      forever begin
         @(posedge clock);
         if (!reset_n) begin
            ca = 0; cb = 0; cc = 0; md = 1'b0; movf = 1'b0;
            ha = 1'b0; hb = 1'b0; hc = 1'b0;
            q.delete();
         end else begin
            m    = {~c & hc, b & ~hb, a ^ ha};
            full = (q.size() == 4);
            pop  = (q.size() != 0) && ev_ready;
            drop = 1'b0;
            if (pop) q.delete(0);
            if (m != 3'b000) begin
               md = ~md;
               if (m[0]) ca++;
               if (m[1]) cb++;
               if (m[2]) cc++;
               if (!full || pop) q.push_back(m);
               else drop = 1'b1;
            end
            movf = drop ? 1'b1 : (clr_ovf ? 1'b0 : movf);
            ha = a; hb = b; hc = c;
         end
         #2;
         chk("d", d, md);
         chk("cnt_a", cnt_a, sat(ca, 255));
         chk("cnt_b", cnt_b, sat(cb, 255));
         chk("cnt_c", cnt_c, sat(cc, 255));
         chk("ev_valid", ev_valid, q.size() != 0);
         chk("ev_data", ev_data, (q.size() != 0) ? q[0] : 3'b000);
         chk("overflow", overflow, movf);
         chk("cnt_a_w2", cnt_a2, sat(ca, 3));
         chk("cnt_b_w2", cnt_b2, sat(cb, 3));
         chk("cnt_c_w2", cnt_c2, sat(cc, 3));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      reset_n = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(10);
      chk("idle_d", d, 0);
      chk("idle_cnt_a", cnt_a, 0);
      chk("idle_valid", ev_valid, 0);
      chk("idle_ovf", overflow, 0);

      // c half-period 5 (starts high), b half-period 7 (starts low)
      ev_ready = 1'b1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         b = ((cyc / 7) % 2) == 1;
         c = ((cyc / 5) % 2) == 0;
         tick(1);
      end
      tick(2);
      chk("wave_cnt_c", cnt_c, 10);
      chk("wave_cnt_b", cnt_b, 7);
      chk("wave_d", d, 0);
      chk("wave_cnt_b_w2", cnt_b2, 3);
      chk("wave_empty", ev_valid, 0);

      // a pulse
      a = 1'b1;
      tick(1);
      chk("pulse_d1", d, 1);
      chk("pulse_valid", ev_valid, 1);
      chk("pulse_data", ev_data, 3'b001);
      tick(4);
      a = 1'b0;
      tick(1);
      chk("pulse_cnt_a", cnt_a, 2);
      chk("pulse_d0", d, 0);
      chk("pulse_data2", ev_data, 3'b001);
      tick(2);

      // b rise and c fall together
      c = 1'b1;
      tick(1);
      b = 1'b1; c = 1'b0;
      tick(1);
      chk("coinc_data", ev_data, 3'b110);
      chk("coinc_cnt_b", cnt_b, 8);
      chk("coinc_cnt_c", cnt_c, 11);
      chk("coinc_d", d, 1);
      tick(2);

      // fill, overflow, clear, set-wins
      ev_ready = 1'b0;
      tick(1);
      for (int i = 0; i < 4; i++) begin
         a = ~a;
         tick(1);
      end
      chk("full_valid", ev_valid, 1);
      chk("full_ovf0", overflow, 0);
      a = ~a;
      tick(1);
      chk("drop_ovf", overflow, 1);
      chk("drop_cnt_a", cnt_a, 7);
      chk("drop_d", d, 0);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      chk("clr_ovf", overflow, 0);
      clr_ovf = 1'b1; a = ~a;
      tick(1);
      clr_ovf = 1'b0;
      chk("setwins_ovf", overflow, 1);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      ev_ready = 1'b1;
      tick(4);
      chk("drain_valid", ev_valid, 0);

      // wrap-around: fill to full, then push+pop while full
      for (int i = 0; i < 6; i++) begin
         ev_ready = (i >= 4);
         a = ~a;
         if (i == 2) b = 1'b0;
         if (i == 4) b = 1'b1;
         if (i == 3) c = 1'b1;
         if (i == 5) c = 1'b0;
         tick(1);
      end
      chk("wrap_ovf", overflow, 0);
      chk("wrap_valid", ev_valid, 1);
      ev_ready = 1'b1;
      tick(6);
      chk("wrap_drained", ev_valid, 0);

      // asynchronous reset with queued entries
      ev_ready = 1'b0;
      a = ~a;
      tick(1);
      a = ~a;
      tick(1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_d", d, 0);
      chk("rst_cnt_a", cnt_a, 0);
      chk("rst_cnt_b", cnt_b, 0);
      chk("rst_cnt_c", cnt_c, 0);
      chk("rst_valid", ev_valid, 0);
      chk("rst_data", ev_data, 0);
      chk("rst_ovf", overflow, 0);
      a = 1'b1; b = 1'b0; c = 1'b1;
      tick(2);
      reset_n = 1'b1;
      tick(1);
      chk("rel_data", ev_data, 3'b001);
      chk("rel_valid", ev_valid, 1);
      chk("rel_d", d, 1);
      chk("rel_cnt_c", cnt_c, 0);
      tick(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
